// File: rtl/ibex_ex_imd_arb.sv
// Arbiter for the two intermediate-value registers shared by the multdiv,
// pext and alu units. It grants one requester and drops writes from the others.
module ibex_ex_imd_arb #(
    parameter int unsigned Width       = 34,
    parameter bit          ClearOnKill = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [2:0]         req_i,
    input  logic [2:0]         done_i,
    input  logic [5:0]         imd_we_i,
    input  logic [6*Width-1:0] imd_d_i,
    input  logic               kill_i,
    output logic [Width-1:0]   imd_q0_o,
    output logic [Width-1:0]   imd_q1_o,
    output logic [2:0]         gnt_o,
    output logic [2:0]         stall_o,
    output logic               busy_o,
    output logic               wr_err_o
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [Width-1:0] imd0_q, imd0_d;
    logic [Width-1:0] imd1_q, imd1_d;

    logic [2:0]       gnt;
    logic [1:0]       gidx;
    logic [1:0]       sel_we;
    logic [Width-1:0] sel_d0, sel_d1;
    logic [2:0]       we_any;

    always_comb begin
        gnt  = '0;
        gidx = '0;
        if (state_q == BUSY) begin
            gidx = owner_q;
            gnt  = 3'b001 << owner_q;
        end else begin
            priority case (1'b1)
                req_i[0]: begin gnt = 3'b001; gidx = 2'd0; end
                req_i[1]: begin gnt = 3'b010; gidx = 2'd1; end
                req_i[2]: begin gnt = 3'b100; gidx = 2'd2; end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_we = '0;
        sel_d0 = '0;
        sel_d1 = '0;
        case (gidx)
            2'd0: begin
                sel_we = imd_we_i[1:0];
                sel_d0 = imd_d_i[0*Width +: Width];
                sel_d1 = imd_d_i[1*Width +: Width];
            end
            2'd1: begin
                sel_we = imd_we_i[3:2];
                sel_d0 = imd_d_i[2*Width +: Width];
                sel_d1 = imd_d_i[3*Width +: Width];
            end
            2'd2: begin
                sel_we = imd_we_i[5:4];
                sel_d0 = imd_d_i[4*Width +: Width];
                sel_d1 = imd_d_i[5*Width +: Width];
            end
            default: ;
        endcase
    end

    assign we_any = {|imd_we_i[5:4], |imd_we_i[3:2], |imd_we_i[1:0]};

    // Release is decided here; a new grant is only formed from IDLE next cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        imd0_d  = imd0_q;
        imd1_d  = imd1_q;
        if (kill_i) begin
            state_d = IDLE;
            if (ClearOnKill) begin
                imd0_d = '0;
                imd1_d = '0;
            end
        end else begin
            if (|gnt) begin
                if (sel_we[0]) imd0_d = sel_d0;
                if (sel_we[1]) imd1_d = sel_d1;
            end
            unique case (state_q)
                IDLE: begin
                    if (|gnt && !done_i[gidx]) begin
                        state_d = BUSY;
                        owner_d = gidx;
                    end
                end
                BUSY: begin
                    if (done_i[owner_q] || !req_i[owner_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            imd0_q  <= '0;
            imd1_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            imd0_q  <= imd0_d;
            imd1_q  <= imd1_d;
        end
    end

    assign gnt_o    = gnt;
    assign stall_o  = req_i & ~gnt;
    assign busy_o   = (state_q == BUSY);
    assign wr_err_o = |(we_any & ~gnt);
    assign imd_q0_o = imd0_q;
    assign imd_q1_o = imd1_q;

endmodule
